// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - washing-machine program controller feeding the display/LED view stage
// Optional feature macro: WASH_AUTO_RESUME_EN (lid closing in error resumes without a button press).
module wash_sequencer #(
  parameter int T_INW        = 3,
  parameter int T_WASH       = 9,
  parameter int T_OUT        = 3,
  parameter int T_SPIN       = 3,
  parameter int T_RINSE      = 6,
  parameter int BEGIN_TICKS  = 2,
  parameter int FINISH_TICKS = 5,
  parameter int CLICK_CYCLES = 4
) (
  input  logic       cp,
  input  logic       reset,
  input  logic       tick,
  input  logic       powerBtn,
  input  logic       startBtn,
  input  logic       modeBtn,
  input  logic       doorOpen,
  output logic [2:0] state,
  output logic [9:0] data,
  output logic [2:0] shinning,
  output logic [5:0] inLeft,
  output logic [5:0] inMiddle,
  output logic [5:0] inRight,
  output logic       click
);

  typedef enum logic [2:0] {
    stShutDown = 3'd0,
    stBegin    = 3'd1,
    stSet      = 3'd2,
    stRun      = 3'd3,
    stError    = 3'd4,
    stPause    = 3'd5,
    stFinish   = 3'd6
  } stateT;

  localparam int CW = $clog2(CLICK_CYCLES + 1);

  stateT         cur;
  logic [2:0]    mode;
  logic [7:0]    tickCnt;
  logic [CW-1:0] clickCnt;
`ifdef WASH_AUTO_RESUME_EN
  logic          fromSet;
`endif

  function automatic logic [5:0] phaseDur(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd4: phaseDur = 6'(T_INW);
      3'd1:       phaseDur = 6'(T_WASH);
      3'd2, 3'd6: phaseDur = 6'(T_OUT);
      3'd3, 3'd7: phaseDur = 6'(T_SPIN);
      default:    phaseDur = 6'(T_RINSE);
    endcase
  endfunction

  function automatic logic [7:0] modeMask(input logic [2:0] m);
    case (m)
      3'd0:    modeMask = 8'hFF;
      3'd1:    modeMask = 8'hC0;
      3'd2:    modeMask = 8'hFC;
      3'd3:    modeMask = 8'h3F;
      3'd4:    modeMask = 8'h3C;
      default: modeMask = 8'h03;
    endcase
  endfunction

  // Mask bit 7 is phase 0, so the lowest phase index is the most significant set bit.
  function automatic logic [2:0] firstPhase(input logic [7:0] mask);
    casez (mask)
      8'b1???????: firstPhase = 3'd0;
      8'b01??????: firstPhase = 3'd1;
      8'b001?????: firstPhase = 3'd2;
      8'b0001????: firstPhase = 3'd3;
      8'b00001???: firstPhase = 3'd4;
      8'b000001??: firstPhase = 3'd5;
      8'b0000001?: firstPhase = 3'd6;
      default:     firstPhase = 3'd7;
    endcase
  endfunction

  function automatic logic [6:0] maskTotal(input logic [7:0] mask);
    maskTotal = '0;
    for (int i = 0; i < 8; i++)
      if (mask[3'(7 - i)]) maskTotal = maskTotal + 7'(phaseDur(3'(i)));
  endfunction

  logic [2:0] nextMode, viewMode;
  logic [7:0] viewMask, remMask;
  logic [6:0] viewTotal;
  logic [5:0] viewTens, viewOnes, viewFirst;
  logic       doorEvt, pressAccepted;

  // viewMode is the mode about to be displayed: the next one in set, mode 0 when arriving from begin.
  always_comb begin
    nextMode      = (mode == 3'd5) ? 3'd0 : mode + 3'd1;
    viewMode      = (cur == stSet) ? nextMode : 3'd0;
    viewMask      = modeMask(viewMode);
    viewTotal     = maskTotal(viewMask);
    viewTens      = 6'(viewTotal / 7'd10);
    viewOnes      = 6'(viewTotal % 7'd10);
    viewFirst     = phaseDur(firstPhase(viewMask));
    remMask       = data[7:0] & ~(8'h80 >> shinning);
    doorEvt       = doorOpen && (cur == stRun || cur == stPause);
    pressAccepted = powerBtn
                 || (!doorEvt && startBtn && (cur == stSet || cur == stRun || cur == stPause))
                 || (!doorEvt && !startBtn && modeBtn && cur == stSet);
  end

  assign state = cur;

  always_ff @(posedge cp or posedge reset) begin
    if (reset) begin
      cur      <= stShutDown;
      data     <= '0;
      shinning <= '0;
      inLeft   <= '0;
      inMiddle <= '0;
      inRight  <= '0;
      mode     <= '0;
      tickCnt  <= '0;
`ifdef WASH_AUTO_RESUME_EN
      fromSet  <= 1'b0;
`endif
    end else if (powerBtn) begin
      if (cur == stShutDown) begin
        cur     <= stBegin;
        data    <= 10'h100;
        tickCnt <= '0;
      end else begin
        cur      <= stShutDown;
        data     <= '0;
        inLeft   <= '0;
        inMiddle <= '0;
        inRight  <= '0;
        mode     <= '0;
      end
    end else if (doorEvt) begin
      cur <= stError;
`ifdef WASH_AUTO_RESUME_EN
      fromSet <= 1'b0;
`endif
    end else begin
      case (cur)
        stBegin: if (tick) begin
          if (tickCnt == 8'(BEGIN_TICKS - 1)) begin
            cur      <= stSet;
            mode     <= 3'd0;
            data     <= {2'b11, viewMask};
            inLeft   <= viewTens;
            inRight  <= viewOnes;
            inMiddle <= viewFirst;
          end else begin
            tickCnt <= tickCnt + 8'd1;
          end
        end
        stSet: if (startBtn) begin
          cur      <= doorOpen ? stError : stRun;
          data[9]  <= 1'b0;
          shinning <= firstPhase(data[7:0]);
          inMiddle <= phaseDur(firstPhase(data[7:0]));
`ifdef WASH_AUTO_RESUME_EN
          fromSet  <= 1'b1;
`endif
        end else if (modeBtn) begin
          mode      <= nextMode;
          data[7:0] <= viewMask;
          inLeft    <= viewTens;
          inRight   <= viewOnes;
          inMiddle  <= viewFirst;
        end
        stRun: if (startBtn) begin
          cur <= stPause;
        end else if (tick) begin
          if (inRight != 6'd0) begin
            inRight <= inRight - 6'd1;
          end else if (inLeft != 6'd0) begin
            inLeft  <= inLeft - 6'd1;
            inRight <= 6'd9;
          end
          if (inMiddle == 6'd1) begin
            data[7:0] <= remMask;
            if (remMask == 8'd0) begin
              cur      <= stFinish;
              tickCnt  <= '0;
              inMiddle <= '0;
            end else begin
              shinning <= firstPhase(remMask);
              inMiddle <= phaseDur(firstPhase(remMask));
            end
          end else begin
            inMiddle <= inMiddle - 6'd1;
          end
        end
        stPause: if (startBtn) cur <= stRun;
        stError: if (!doorOpen) begin
`ifdef WASH_AUTO_RESUME_EN
          if (fromSet) begin
            cur     <= stSet;
            data[9] <= 1'b1;
          end else begin
            cur <= stRun;
          end
`else
          cur <= stPause;
`endif
        end
        stFinish: if (tick) begin
          if (tickCnt == 8'(FINISH_TICKS - 1)) begin
            cur      <= stShutDown;
            data     <= '0;
            inLeft   <= '0;
            inMiddle <= '0;
            inRight  <= '0;
            mode     <= '0;
          end else begin
            tickCnt <= tickCnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge cp or posedge reset) begin
    if (reset) begin
      clickCnt <= '0;
      click    <= 1'b0;
    end else if (pressAccepted) begin
      clickCnt <= CW'(CLICK_CYCLES - 1);
      click    <= 1'b1;
    end else if (clickCnt != '0) begin
      clickCnt <= clickCnt - 1'b1;
    end else begin
      click <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - randomized self-checking bench for wash_sequencer with a phase-list reference model
module tb_wash_sequencer;

  localparam int T_INW = 3, T_WASH = 9, T_OUT = 3, T_SPIN = 3, T_RINSE = 6;
  localparam int BEGIN_TICKS = 2, FINISH_TICKS = 5, CLICK_CYCLES = 4;
  localparam int ST_SHUT = 0, ST_BEGIN = 1, ST_SET = 2, ST_RUN = 3, ST_ERR = 4, ST_PAUSE = 5, ST_FIN = 6;

  logic       cp = 1'b0;
  logic       reset, tick, powerBtn, startBtn, modeBtn, doorOpen;
  logic [2:0] state;
  logic [9:0] data;
  logic [2:0] shinning;
  logic [5:0] inLeft, inMiddle, inRight;
  logic       click;

  int checks = 0;
  int failures = 0;

  int mSt, mMode, mShin, mTotal, mTicks, mClick;
`ifdef WASH_AUTO_RESUME_EN
  bit mFromSet;
`endif
  bit pend[8];
  int rem[8];
  int dur[8] = '{T_INW, T_WASH, T_OUT, T_SPIN, T_INW, T_RINSE, T_OUT, T_SPIN};
  logic [7:0] modeTab[6] = '{8'hFF, 8'hC0, 8'hFC, 8'h3F, 8'h3C, 8'h03};

  wash_sequencer #(
    .T_INW(T_INW), .T_WASH(T_WASH), .T_OUT(T_OUT), .T_SPIN(T_SPIN), .T_RINSE(T_RINSE),
    .BEGIN_TICKS(BEGIN_TICKS), .FINISH_TICKS(FINISH_TICKS), .CLICK_CYCLES(CLICK_CYCLES)
  ) dut (
    .cp(cp), .reset(reset), .tick(tick), .powerBtn(powerBtn), .startBtn(startBtn),
    .modeBtn(modeBtn), .doorOpen(doorOpen), .state(state), .data(data), .shinning(shinning),
    .inLeft(inLeft), .inMiddle(inMiddle), .inRight(inRight), .click(click)
  );

  always #5 cp = ~cp;

  function automatic int firstPend();
    for (int i = 0; i < 8; i++) if (pend[i]) return i;
    return 0;
  endfunction

  function automatic bit anyPend();
    for (int i = 0; i < 8; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] pendBits();
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) b = {b[6:0], pend[i]};
    return b;
  endfunction

  task automatic modelReset();
    mSt = ST_SHUT; mMode = 0; mShin = 0; mTotal = 0; mTicks = 0; mClick = 0;
    for (int i = 0; i < 8; i++) begin pend[i] = 1'b0; rem[i] = 0; end
  endtask

  task automatic powerDown();
    mSt = ST_SHUT; mMode = 0; mTotal = 0;
    for (int i = 0; i < 8; i++) pend[i] = 1'b0;
  endtask

  task automatic enterSet(input int md);
    logic [7:0] m = modeTab[md];
    mSt = ST_SET; mMode = md; mTotal = 0;
    for (int i = 0; i < 8; i++) begin
      pend[i] = m[7];
      m = m << 1;
      rem[i] = dur[i];
      if (pend[i]) mTotal += dur[i];
    end
  endtask

  task automatic modelStep(input logic p, s, m, d, t);
    bit accepted = 1'b0;
    if (p) begin
      accepted = 1'b1;
      if (mSt == ST_SHUT) begin mSt = ST_BEGIN; mTicks = 0; end
      else powerDown();
    end else if (d && (mSt == ST_RUN || mSt == ST_PAUSE)) begin
      mSt = ST_ERR;
`ifdef WASH_AUTO_RESUME_EN
      mFromSet = 1'b0;
`endif
    end else begin
      case (mSt)
        ST_BEGIN: if (t) begin
          mTicks++;
          if (mTicks == BEGIN_TICKS) enterSet(0);
        end
        ST_SET: if (s) begin
          accepted = 1'b1;
          mSt = d ? ST_ERR : ST_RUN;
          mShin = firstPend();
`ifdef WASH_AUTO_RESUME_EN
          mFromSet = 1'b1;
`endif
        end else if (m) begin
          accepted = 1'b1;
          enterSet((mMode + 1) % 6);
        end
        ST_RUN: if (s) begin
          accepted = 1'b1;
          mSt = ST_PAUSE;
        end else if (t) begin
          rem[mShin]--;
          if (mTotal > 0) mTotal--;
          if (rem[mShin] == 0) begin
            pend[mShin] = 1'b0;
            if (anyPend()) mShin = firstPend();
            else begin mSt = ST_FIN; mTicks = 0; end
          end
        end
        ST_PAUSE: if (s) begin accepted = 1'b1; mSt = ST_RUN; end
        ST_ERR: if (!d) begin
`ifdef WASH_AUTO_RESUME_EN
          mSt = mFromSet ? ST_SET : ST_RUN;
`else
          mSt = ST_PAUSE;
`endif
        end
        ST_FIN: if (t) begin
          mTicks++;
          if (mTicks == FINISH_TICKS) powerDown();
        end
        default: ;
      endcase
    end
    if (accepted) mClick = CLICK_CYCLES;
    else if (mClick > 0) mClick--;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    int mid, tot;
    logic [9:0] ed;
    if (mSt == ST_SET) begin mid = dur[firstPend()]; tot = mTotal; end
    else if (mSt >= ST_RUN) begin mid = rem[mShin]; tot = mTotal; end
    else begin mid = 0; tot = 0; end
    if (mSt == ST_SHUT) ed = '0;
    else if (mSt == ST_BEGIN) ed = 10'h100;
    else ed = {mSt == ST_SET, 1'b1, pendBits()};
    chk({tag, ".state"}, 32'(state), 32'(mSt));
    chk({tag, ".data"}, 32'(data), 32'(ed));
    chk({tag, ".shinning"}, 32'(shinning), 32'(mShin));
    chk({tag, ".inLeft"}, 32'(inLeft), 32'(tot / 10));
    chk({tag, ".inMiddle"}, 32'(inMiddle), 32'(mid));
    chk({tag, ".inRight"}, 32'(inRight), 32'(tot % 10));
    chk({tag, ".click"}, 32'(click), 32'(mClick > 0));
  endtask

  task automatic cyc(input logic p, s, m, d, t, input string tag);
    powerBtn = p; startBtn = s; modeBtn = m; doorOpen = d; tick = t;
    @(posedge cp);
    modelStep(p, s, m, d, t);
    #1;
    powerBtn = 1'b0; startBtn = 1'b0; modeBtn = 1'b0; tick = 1'b0;
    checkAll(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, doorOpen, 1'b0, "idle");
  endtask

  task automatic ticks(input int n, input string tag);
    repeat (n) begin
      idle($urandom_range(0, 2));
      cyc(1'b0, 1'b0, 1'b0, doorOpen, 1'b1, tag);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic dRand;
    reset = 1'b1; tick = 1'b0; powerBtn = 1'b0; startBtn = 1'b0; modeBtn = 1'b0; doorOpen = 1'b0;
    modelReset();
    repeat (2) @(posedge cp);
    #1;
    checkAll("reset");
    reset = 1'b0;
    idle(2);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "powerOn");
    chk("powerOn.stateBegin", 32'(state), 32'd1);
    ticks(BEGIN_TICKS, "greet");
    chk("set.data", 32'(data), 32'h3FF);
    chk("set.digits", 32'({inLeft, inMiddle, inRight}), 32'({6'd3, 6'd3, 6'd3}));

    repeat (5) begin
      idle($urandom_range(0, 2));
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "mode");
    end
    chk("mode5.mask", 32'(data[7:0]), 32'h03);
    chk("mode5.total", 32'({inLeft, inRight}), 32'({6'd0, 6'd6}));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "modeWrap");
    chk("modeWrap.mask", 32'(data[7:0]), 32'hFF);

    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "mode1");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "start1");
    ticks(3, "washFill");
    chk("mode1.shinning", 32'(shinning), 32'd1);
    chk("mode1.mask", 32'(data[7:0]), 32'h40);
    chk("mode1.inMiddle", 32'(inMiddle), 32'd9);
    ticks(9, "wash");
    chk("mode1.finish", 32'(state), 32'd6);
    ticks(FINISH_TICKS, "finish");
    chk("mode1.off", 32'(state), 32'd0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "powerOn2");
    ticks(BEGIN_TICKS, "greet2");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "start0");
    ticks(2, "run0");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "doorTick");
    chk("doorTick.state", 32'(state), 32'd4);
    chk("doorTick.frozen", 32'({inLeft, inMiddle, inRight}), 32'({6'd3, 6'd1, 6'd1}));
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "doorClose");
`ifdef WASH_AUTO_RESUME_EN
    chk("doorClose.state", 32'(state), 32'd3);
`else
    chk("doorClose.state", 32'(state), 32'd5);
`endif
    if (mSt == ST_PAUSE) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "resume");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "startTick");
    chk("startTick.state", 32'(state), 32'd5);
    chk("startTick.frozen", 32'(inMiddle), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "powerOff");
    chk("powerOff.data", 32'(data), 32'd0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "powerOn3");
    ticks(BEGIN_TICKS, "greet3");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "start3");
    ticks(3, "run3");
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll("asyncReset");
    chk("asyncReset.state", 32'(state), 32'd0);
    @(posedge cp);
    @(posedge cp);
    #1;
    checkAll("resetHeld");
    reset = 1'b0;

    dRand = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      logic p, s, m, t;
      p = (mSt == ST_SHUT) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 599) == 0);
      if (dRand) dRand = ($urandom_range(0, 5) != 0);
      else dRand = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 24) == 0);
      m = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 2) == 0);
      cyc(p, s, m, dRand, t, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
